// File: rtl/irq_encoder_pkg.sv
// Shared types for the interrupt front end: FSM state encodings and
// the helper that turns an index width into a request-line count.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_e;

    localparam int CW_DEFAULT = 2;
    localparam int N_DEFAULT  = 2 ** CW_DEFAULT;

    function automatic int numLines(input int cw);
        return 1 << cw;
    endfunction

endpackage

// File: rtl/irq_encoder_prio_enc.sv
// Combinational priority encoder over MSB-first line packing:
// line k sits at v[N-1-k], and line 0 has the highest priority.
module prio_enc
    import irq_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic [numLines(CW)-1:0] v,
    output logic                    any,
    output logic [CW-1:0]           idx
);

    localparam int N = numLines(CW);

    assign any = |v;

    // Walk from the lowest-priority line upward so the highest-priority hit is written last.
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (v[N-1-k]) begin
                idx = CW'(k);
            end
        end
    end

endmodule

// File: rtl/irq_encoder.sv
// Interrupt front end: edge-latches request lines into a pending set,
// masks them, and hands the highest-priority line to the CPU via req/ack/eoi.
module irq_encoder
    import irq_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [numLines(CW)-1:0] irq,
    input  logic [numLines(CW)-1:0] mask,
    output logic                    req,
    output logic [CW-1:0]           id,
    output logic                    busy,
    output logic [numLines(CW)-1:0] pend,
    input  logic                    ack,
    input  logic                    eoi
);

    localparam int N = numLines(CW);

    state_e          state_q, state_d;
    logic [N-1:0]    prev_q;
    logic [N-1:0]    pend_q, pend_d;
    logic [CW-1:0]   id_q, id_d;
    logic            req_q, req_d;
    logic            busy_q, busy_d;

    logic [N-1:0]    rise;
    logic [N-1:0]    clr;
    logic [N-1:0]    cand;
    logic            candAny;
    logic [CW-1:0]   candIdx;

    assign rise = irq & ~prev_q;
    assign cand = pend_q & mask;

    // A rise on the line being acked wins over its clear, so a fresh event is not lost.
    always_comb begin
        clr = '0;
        for (int k = 0; k < N; k++) begin
            clr[N-1-k] = (state_q == REQ) && ack && (id_q == CW'(k));
        end
        pend_d = (pend_q & ~clr) | rise;
    end

    prio_enc #(
        .CW (CW)
    ) u_prio_enc (
        .v   (cand),
        .any (candAny),
        .idx (candIdx)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        req_d   = req_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                req_d  = 1'b0;
                busy_d = 1'b0;
                if (candAny) begin
                    state_d = REQ;
                    id_d    = candIdx;
                    req_d   = 1'b1;
                end
            end
            REQ: begin
                if (ack) begin
                    state_d = SERV;
                    req_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SERV: begin
                if (eoi) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // prev tracks irq even in reset so lines already high never look like edges.
    always_ff @(posedge clk) begin
        prev_q <= irq;
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            id_q    <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
        end
    end

    assign req  = req_q;
    assign id   = id_q;
    assign busy = busy_q;
    assign pend = pend_q;

endmodule

// File: tb/tb_irq_encoder.sv
// Directed scoreboard bench for irq_encoder with CW=2: expectations are
// queued as each step is driven and popped once the clock edge has landed.
module tb_irq_encoder;

    localparam int CW = 2;
    localparam int N  = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  irq;
    logic [N-1:0]  mask;
    logic          ack;
    logic          eoi;
    logic          req;
    logic [CW-1:0] id;
    logic          busy;
    logic [N-1:0]  pend;

    typedef struct {
        string         tag;
        logic          req;
        logic [CW-1:0] id;
        logic          busy;
        logic [N-1:0]  pend;
    } exp_t;

    exp_t sb[$];
    int   passCount;
    int   totalCount;

    irq_encoder #(
        .CW (CW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .irq  (irq),
        .mask (mask),
        .req  (req),
        .id   (id),
        .busy (busy),
        .pend (pend),
        .ack  (ack),
        .eoi  (eoi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, optionally queue the outputs expected after the edge.
    task automatic applyStimulus(input logic rstV, input logic [N-1:0] irqV,
                                 input logic [N-1:0] maskV, input logic ackV,
                                 input logic eoiV, input bit doExp, input string tag,
                                 input logic eReq, input logic [CW-1:0] eId,
                                 input logic eBusy, input logic [N-1:0] ePend);
        exp_t e;
        @(negedge clk);
        rst  = rstV;
        irq  = irqV;
        mask = maskV;
        ack  = ackV;
        eoi  = eoiV;
        if (doExp) begin
            e.tag  = tag;
            e.req  = eReq;
            e.id   = eId;
            e.busy = eBusy;
            e.pend = ePend;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        totalCount++;
        assert (sb.size() != 0) passCount++;
        else $error("FAIL scoreboard_empty: queue size %0d, required nonzero", sb.size());
        if (sb.size() != 0) begin
            e = sb.pop_front();
            totalCount++;
            assert (req === e.req) passCount++;
            else $error("FAIL %s.req: got %b, expected %b", e.tag, req, e.req);
            totalCount++;
            assert (id === e.id) passCount++;
            else $error("FAIL %s.id: got %0d, expected %0d", e.tag, id, e.id);
            totalCount++;
            assert (busy === e.busy) passCount++;
            else $error("FAIL %s.busy: got %b, expected %b", e.tag, busy, e.busy);
            totalCount++;
            assert (pend === e.pend) passCount++;
            else $error("FAIL %s.pend: got %b, expected %b", e.tag, pend, e.pend);
        end
    endtask

    // step with check: rst irq mask ack eoi | tag req id busy pend
    task automatic sc(input logic r, input logic [N-1:0] i, input logic [N-1:0] m,
                      input logic a, input logic e, input string tag, input logic eReq,
                      input logic [CW-1:0] eId, input logic eBusy, input logic [N-1:0] ePend);
        applyStimulus(r, i, m, a, e, 1'b1, tag, eReq, eId, eBusy, ePend);
        checkOutput();
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        rst  = 1'b1;
        irq  = '0;
        mask = 4'b1111;
        ack  = 1'b0;
        eoi  = 1'b0;
        $display("[TB] starting irq_encoder bench");

        sc(1, 4'b0000, 4'b1111, 0, 0, "reset",      0, 2'd0, 0, 4'b0000);

        // single line 2
        sc(0, 4'b0010, 4'b1111, 0, 0, "t1_pend",    0, 2'd0, 0, 4'b0010);
        sc(0, 4'b0010, 4'b1111, 0, 0, "t1_req",     1, 2'd2, 0, 4'b0010);
        sc(0, 4'b0010, 4'b1111, 1, 0, "t1_ack",     0, 2'd2, 1, 4'b0000);
        sc(0, 4'b0010, 4'b1111, 0, 1, "t1_eoi",     0, 2'd2, 0, 4'b0000);

        // lines 1 and 3 together
        sc(0, 4'b0101, 4'b1111, 0, 0, "t2_pend",    0, 2'd2, 0, 4'b0101);
        sc(0, 4'b0101, 4'b1111, 0, 0, "t2_req1",    1, 2'd1, 0, 4'b0101);
        sc(0, 4'b0101, 4'b1111, 1, 0, "t2_ack1",    0, 2'd1, 1, 4'b0001);
        sc(0, 4'b0101, 4'b1111, 0, 1, "t2_eoi1",    0, 2'd1, 0, 4'b0001);
        sc(0, 4'b0101, 4'b1111, 0, 0, "t2_req3",    1, 2'd3, 0, 4'b0001);
        sc(0, 4'b0101, 4'b1111, 1, 0, "t2_ack3",    0, 2'd3, 1, 4'b0000);
        sc(0, 4'b0101, 4'b1111, 0, 1, "t2_eoi3",    0, 2'd3, 0, 4'b0000);

        // masked line 0
        sc(0, 4'b0000, 4'b1111, 0, 0, "t3_quiet",   0, 2'd3, 0, 4'b0000);
        sc(0, 4'b1000, 4'b0111, 0, 0, "t3_pend",    0, 2'd3, 0, 4'b1000);
        sc(0, 4'b1000, 4'b0111, 0, 0, "t3_masked",  0, 2'd3, 0, 4'b1000);
        applyStimulus(0, 4'b1000, 4'b1111, 0, 0, 1'b0, "", 0, 2'd0, 0, 4'b0000);
        sc(0, 4'b1000, 4'b1111, 0, 0, "t3_req0",    1, 2'd0, 0, 4'b1000);
        sc(0, 4'b1000, 4'b1111, 1, 0, "t3_ack",     0, 2'd0, 1, 4'b0000);
        sc(0, 4'b1000, 4'b1111, 0, 1, "t3_eoi",     0, 2'd0, 0, 4'b0000);

        // higher priority arrives during REQ
        sc(0, 4'b0010, 4'b1111, 0, 0, "t4_pend2",   0, 2'd0, 0, 4'b0010);
        sc(0, 4'b0010, 4'b1111, 0, 0, "t4_req2",    1, 2'd2, 0, 4'b0010);
        sc(0, 4'b1010, 4'b1111, 0, 0, "t4_rise0",   1, 2'd2, 0, 4'b1010);
        sc(0, 4'b1010, 4'b1111, 0, 0, "t4_hold",    1, 2'd2, 0, 4'b1010);
        sc(0, 4'b1010, 4'b1111, 1, 0, "t4_ack2",    0, 2'd2, 1, 4'b1000);
        sc(0, 4'b1010, 4'b1111, 0, 0, "t4_nonest",  0, 2'd2, 1, 4'b1000);
        sc(0, 4'b1010, 4'b1111, 0, 1, "t4_eoi2",    0, 2'd2, 0, 4'b1000);
        sc(0, 4'b1010, 4'b1111, 0, 0, "t4_req0",    1, 2'd0, 0, 4'b1000);
        sc(0, 4'b1010, 4'b1111, 1, 0, "t4_ack0",    0, 2'd0, 1, 4'b0000);
        sc(0, 4'b1010, 4'b1111, 0, 1, "t4_eoi0",    0, 2'd0, 0, 4'b0000);

        // rise of line 2 coincident with its ack
        sc(0, 4'b0000, 4'b1111, 0, 0, "t5_quiet",   0, 2'd0, 0, 4'b0000);
        sc(0, 4'b0010, 4'b1111, 0, 0, "t5_pend",    0, 2'd0, 0, 4'b0010);
        sc(0, 4'b0000, 4'b1111, 0, 0, "t5_req",     1, 2'd2, 0, 4'b0010);
        sc(0, 4'b0010, 4'b1111, 1, 0, "t5_ackrise", 0, 2'd2, 1, 4'b0010);
        sc(0, 4'b0010, 4'b1111, 0, 1, "t5_eoi",     0, 2'd2, 0, 4'b0010);
        sc(0, 4'b0010, 4'b1111, 0, 0, "t5_rereq",   1, 2'd2, 0, 4'b0010);
        sc(0, 4'b0010, 4'b1111, 1, 0, "t5_ack2",    0, 2'd2, 1, 4'b0000);
        sc(0, 4'b0010, 4'b1111, 0, 1, "t5_eoi2",    0, 2'd2, 0, 4'b0000);

        // irq held through reset, reset while busy, stray ack/eoi
        sc(1, 4'b0100, 4'b1111, 0, 0, "t6_rst",     0, 2'd0, 0, 4'b0000);
        sc(0, 4'b0100, 4'b1111, 0, 0, "t6_noedge",  0, 2'd0, 0, 4'b0000);
        sc(0, 4'b0100, 4'b1111, 0, 0, "t6_noreq",   0, 2'd0, 0, 4'b0000);
        sc(0, 4'b0000, 4'b1111, 0, 0, "t6_low",     0, 2'd0, 0, 4'b0000);
        sc(0, 4'b0001, 4'b1111, 0, 0, "t6_pend3",   0, 2'd0, 0, 4'b0001);
        sc(0, 4'b0001, 4'b1111, 0, 0, "t6_req3",    1, 2'd3, 0, 4'b0001);
        sc(0, 4'b0001, 4'b1111, 1, 0, "t6_ack3",    0, 2'd3, 1, 4'b0000);
        sc(0, 4'b0011, 4'b1111, 0, 0, "t6_pend2",   0, 2'd3, 1, 4'b0010);
        sc(1, 4'b0011, 4'b1111, 0, 0, "t6_rstbusy", 0, 2'd0, 0, 4'b0000);
        sc(0, 4'b0011, 4'b1111, 1, 0, "t6_strayack",0, 2'd0, 0, 4'b0000);
        sc(0, 4'b0011, 4'b1111, 0, 1, "t6_strayeoi",0, 2'd0, 0, 4'b0000);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
